// File: rtl/rgb_status_pwm.sv
// Status-to-LED encoder: latches a 2-bit self-test status and drives the three
// RGB PWM enables with period-aligned brightness and blink patterns.
module rgb_status_pwm #(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned PWM_DIV   = 1,
    parameter int unsigned BLINK_DIV = 12000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_status_valid,
    input  logic [1:0]          i_status,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_r,
    output logic                o_pwm_g,
    output logic                o_pwm_b,
    output logic [1:0]          o_state,
    output logic                o_period
);

    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] cnt;
    logic [BLK_W-1:0]    blk;
    logic                ph;
    logic [PWM_BITS-1:0] duty_q;
    logic [2:0]          mask_q, mask_d;
    logic                pre_wrap, period_wrap, blk_wrap;

    assign pre_wrap    = (pre == PRE_LAST);
    assign period_wrap = pre_wrap && (cnt == '1);
    assign blk_wrap    = (blk == BLK_LAST);
    assign o_state     = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre <= '0;
            cnt <= '0;
            blk <= '0;
            ph  <= 1'b0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) cnt <= cnt + 1'b1;
            blk <= blk_wrap ? '0 : blk + 1'b1;
            if (blk_wrap) ph <= ~ph;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FAIL is sticky; mask is {r,g,b} and sampled from the pre-strobe state
    always_comb begin
        state_d = state_q;
        mask_d  = 3'b000;
        if (i_status_valid && state_q != S_FAIL) state_d = state_t'(i_status);
        case (state_q)
            S_IDLE:  mask_d = 3'b001;
            S_RUN:   mask_d = {2'b00, ph};
            S_PASS:  mask_d = 3'b010;
            S_FAIL:  mask_d = {ph, 2'b00};
            default: mask_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_q   <= '0;
            mask_q   <= '0;
            o_period <= 1'b0;
            o_pwm_r  <= 1'b0;
            o_pwm_g  <= 1'b0;
            o_pwm_b  <= 1'b0;
        end else begin
            if (period_wrap) begin
                duty_q <= i_duty;
                mask_q <= mask_d;
            end
            o_period <= period_wrap;
            o_pwm_r  <= mask_q[2] & (cnt < duty_q);
            o_pwm_g  <= mask_q[1] & (cnt < duty_q);
            o_pwm_b  <= mask_q[0] & (cnt < duty_q);
        end
    end

endmodule

// File: tb/tb_rgb_status_pwm.sv
// Scoreboard bench for rgb_status_pwm: per-period on-counts are queued by the
// stimulus and checked by a monitor at each o_period pulse.
module tb_rgb_status_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_status_valid = 1'b0;
    logic [1:0] i_status = 2'd0;
    logic [3:0] i_duty = 4'd4;
    logic       o_pwm_r, o_pwm_g, o_pwm_b, o_period;
    logic [1:0] o_state;

    typedef struct {
        int    r;
        int    g;
        int    b;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   open = 1'b0;
    int   cr, cg, cb;

    rgb_status_pwm #(
        .PWM_BITS (4),
        .PWM_DIV  (1),
        .BLINK_DIV(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_status_valid(i_status_valid),
        .i_status      (i_status),
        .i_duty        (i_duty),
        .o_pwm_r       (o_pwm_r),
        .o_pwm_g       (o_pwm_g),
        .o_pwm_b       (o_pwm_b),
        .o_state       (o_state),
        .o_period      (o_period)
    );

    always #5 clk = ~clk;

    // Monitor: a window runs from one o_period pulse to the next
    always @(negedge clk) begin
        if (!reset) begin
            open = 1'b0;
        end else if (o_period) begin
            if (open) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_period: got r=%0d g=%0d b=%0d, no expectation queued",
                             cr, cg, cb);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cr != e.r || cg != e.g || cb != e.b) begin
                        errors++;
                        $display("FAIL %s: got r=%0d g=%0d b=%0d required r=%0d g=%0d b=%0d",
                                 e.name, cr, cg, cb, e.r, e.g, e.b);
                    end
                end
            end
            open = 1'b1;
            cr = int'(o_pwm_r);
            cg = int'(o_pwm_g);
            cb = int'(o_pwm_b);
        end else if (open) begin
            cr += int'(o_pwm_r);
            cg += int'(o_pwm_g);
            cb += int'(o_pwm_b);
        end
    end

    task automatic push(input int r, input int g, input int b, input string nm);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_period(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_period) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got no o_period within 40 cycles, required one", nm);
    endtask

    task automatic check_val(input string nm, input logic [4:0] got, input logic [4:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic strobe(input logic [1:0] st, input logic [1:0] exp_state, input string nm);
        i_status       = st;
        i_status_valid = 1'b1;
        @(negedge clk);
        i_status_valid = 1'b0;
        check_val(nm, {3'b000, o_state}, {3'b000, exp_state});
    endtask

    task automatic check_quiet_start(input string nm);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_val(nm, {o_pwm_r, o_pwm_g, o_pwm_b, o_period, 1'b0}, 5'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {o_pwm_r, o_pwm_g, o_pwm_b, o_state}, 5'd0);
        check_val("reset_period", {4'd0, o_period}, 5'd0);
        reset = 1'b1;

        // IDLE after reset: quiet first period, then blue 4/16
        check_quiet_start("first_period_quiet");
        wait_period("first_wrap");
        push(0, 0, 4, "idle_k1");
        wait_period("idle_k2");
        push(0, 0, 4, "idle_k2");
        wait_period("idle_k3");

        // PASS strobe mid-period: blue completes, green from next wrap
        push(0, 0, 4, "pass_strobe_blue_finishes");
        repeat (4) @(negedge clk);
        strobe(2'd2, 2'd2, "state_pass");
        wait_period("pass_k4");
        push(0, 4, 0, "pass_green");
        wait_period("pass_k5");

        // Duty changes only at the wrap
        push(0, 4, 0, "duty_mid_change_held");
        repeat (5) @(negedge clk);
        i_duty = 4'd15;
        wait_period("duty_k6");
        push(0, 15, 0, "duty15");
        i_duty = 4'd0;
        wait_period("duty_k7");
        push(0, 0, 0, "duty0");
        i_duty = 4'd4;
        wait_period("duty_k8");

        // Async reset with green high mid-period
        @(negedge clk);
        check_val("green_high_before_reset", {4'd0, o_pwm_g}, 5'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_val("async_reset_outputs", {o_pwm_r, o_pwm_g, o_pwm_b, o_period, 1'b0}, 5'd0);
        check_val("async_reset_state", {3'b000, o_state}, 5'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        check_quiet_start("post_reset_quiet");
        wait_period("post_reset_k1");
        push(0, 0, 4, "post_reset_idle_k1");
        check_val("post_reset_state", {3'b000, o_state}, 5'd0);
        wait_period("post_reset_k2");
        push(0, 0, 4, "post_reset_idle_k2");
        wait_period("post_reset_k3");

        // RUN strobe on the o_period cycle: this period keeps IDLE mask
        push(0, 0, 4, "run_on_wrap_idle_mask");
        strobe(2'd1, 2'd1, "state_run");
        wait_period("run_k4");
        push(0, 0, 0, "run_ph0");
        wait_period("run_k5");
        push(0, 0, 4, "run_ph1");
        wait_period("run_k6");

        // FAIL is sticky; red blinks with ph
        push(0, 0, 4, "run_ph1_before_fail");
        repeat (2) @(negedge clk);
        strobe(2'd3, 2'd3, "state_fail");
        strobe(2'd1, 2'd3, "fail_ignores_run");
        strobe(2'd2, 2'd3, "fail_ignores_pass");
        wait_period("fail_k7");
        push(4, 0, 0, "fail_ph1_k7");
        wait_period("fail_k8");
        push(4, 0, 0, "fail_ph1_k8");
        wait_period("fail_k9");
        push(0, 0, 0, "fail_ph0_k9");
        wait_period("fail_k10");
        push(0, 0, 0, "fail_ph0_k10");
        wait_period("fail_k11");
        push(0, 0, 0, "fail_ph0_k11");
        wait_period("fail_k12");
        push(0, 0, 0, "fail_ph0_k12");
        wait_period("fail_k13");
        push(4, 0, 0, "fail_ph1_k13");
        wait_period("fail_k14");
        check_val("fail_state_final", {3'b000, o_state}, 5'd3);
        @(negedge clk);
        check_val("scoreboard_drained", 5'(exp_q.size()), 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
